// File: rtl/shift_mult16_seq_pkg.sv
// Shared constants for the serial shift-add multiplier and its sequencer.
package shift_mult16_seq_pkg;

   localparam int MULT_B_WIDTH = 8;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_LOAD = LOAD,
      ST_RUN  = RUN,
      ST_DONE = DONE
   } seq_state_t;

endpackage

// File: rtl/shift_mult16_seq.sv
// Sequencer for the negedge serial multiplier: accept operands, run B_WIDTH steps, return result.
// Result valid B_WIDTH+1 cycles after accept; result held in DONE until out_ready, no input queuing.
module shift_mult16_seq
   import shift_mult16_seq_pkg::*;
#(
   parameter int B_WIDTH = MULT_B_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [15:0]        in_a,
   input  logic [B_WIDTH-1:0] in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        out_y,
   output logic               busy,
   output logic               mult_rst,
   output logic [15:0]        mult_a,
   output logic [B_WIDTH-1:0] mult_b,
   input  logic [15:0]        mult_y
);

   localparam int CNT_W = $clog2(B_WIDTH + 1);

   seq_state_t         state;
   logic [CNT_W-1:0]   cnt;
   logic [15:0]        a_q;
   logic [B_WIDTH-1:0] b_q;
   logic [15:0]        y_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         y_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q   <= in_a;
                  b_q   <= in_b;
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               cnt   <= CNT_W'(B_WIDTH);
               state <= ST_RUN;
            end
            ST_RUN: begin
               cnt <= cnt - CNT_W'(1);
               // By this edge the multiplier has taken its B_WIDTH-th negedge step.
               if (cnt == CNT_W'(1)) begin
                  y_q   <= mult_y;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Everything below depends only on registered state.
   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state == ST_LOAD) || (state == ST_RUN);
   assign mult_rst  = (state != ST_RUN);
   assign out_y     = y_q;
   assign mult_a    = a_q;
   assign mult_b    = b_q;

endmodule

// File: tb/tb_shift_mult16_seq.sv
// Directed bench for shift_mult16_seq with a behavioural negedge shift-add multiplier.
module tb_shift_mult16_seq;

   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_a;
   logic [BW-1:0] in_b;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_y;
   logic          busy;
   logic          mult_rst;
   logic [15:0]   mult_a;
   logic [BW-1:0] mult_b;
   logic [15:0]   mult_y;

   int errors = 0;
   int checks = 0;

   shift_mult16_seq #(.B_WIDTH(BW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .busy      (busy),
      .mult_rst  (mult_rst),
      .mult_a    (mult_a),
      .mult_b    (mult_b),
      .mult_y    (mult_y)
   );

   always #5 clk = ~clk;

   // Serial multiplier: one right-shifting add step per negedge.
   logic [15:0]   acc;
   logic [BW-1:0] breg;
   always @(negedge clk) begin
      logic [16:0] sum;
      if (mult_rst) begin
         acc  <= '0;
         breg <= mult_b;
      end else begin
         sum  = {1'b0, acc} + (breg[0] ? {1'b0, mult_a} : 17'd0);
         acc  <= sum[16:1];
         breg <= breg >> 1;
      end
   end
   assign mult_y = acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op from IDLE and wait for out_valid; optionally scramble inputs meanwhile.
   task automatic run_op(input logic [15:0] a, input logic [BW-1:0] b, input bit jitter,
                         output logic [15:0] y, output int lat, output int low_cnt,
                         output bit stable);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      tick();
      lat     = -1;
      low_cnt = 0;
      stable  = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         if (mult_a !== a || mult_b !== b) stable = 1'b0;
         if (jitter) begin
            in_valid = 1'($urandom);
            in_a     = 16'($urandom);
            in_b     = BW'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (!mult_rst) low_cnt++;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
      in_valid = 1'b0;
      y = out_y;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] y;
      logic [15:0] held;
      logic [15:0] ra;
      logic [BW-1:0] rb;
      int lat, low_cnt, acc_n, ov_cnt, rand_bad, rand_lat_bad, rand_unstable;
      int acc_cyc[2];
      int cyc;
      bit stable, ready_seen;

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready",  in_ready,  1);
      check("rst_out_valid", out_valid, 0);
      check("rst_mult_rst",  mult_rst,  1);
      check("rst_out_y",     out_y,     0);
      check("rst_busy",      busy,      0);
      check("rst_mult_a",    mult_a,    0);
      rst = 1'b0;

      // Unknown operands while in_valid is low must not reach the operand regs.
      in_a = 'x; in_b = 'x;
      tick();
      tick();
      check("x_block_a", mult_a, 0);
      check("x_block_b", mult_b, 0);

      run_op(16'h1000, 8'h80, 1'b0, y, lat, low_cnt, stable);
      check("basic_lat",     lat,     9);
      check("basic_y",       y,       16'h0800);
      check("basic_rst_low", low_cnt, 8);
      check("basic_stable",  stable,  1);
      pop();
      check("basic_idle", in_ready, 1);

      run_op(16'h7FFF, 8'hFF, 1'b0, y, lat, low_cnt, stable);
      check("max_y",   y,   16'h7F7F);
      check("max_lat", lat, 9);
      pop();
      run_op(16'h1234, 8'h00, 1'b0, y, lat, low_cnt, stable);
      check("zero_b_y",   y,   16'h0000);
      check("zero_b_lat", lat, 9);

      // Backpressure: hold in DONE with in_valid pulses that must be ignored.
      held = out_y;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_a     = 16'hBEEF;
         in_b     = 8'h55;
         tick();
         check("bp_out_valid", out_valid, 1);
         check("bp_out_y",     out_y,     held);
         check("bp_in_ready",  in_ready,  0);
      end
      in_valid = 1'b0;
      check("bp_mult_a", mult_a, 16'h1234);
      pop();
      check("bp_idle_ready", in_ready,  1);
      check("bp_idle_valid", out_valid, 0);

      // Back-to-back issue with out_ready held high.
      in_a = 16'h0200; in_b = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
      acc_n = 0; cyc = 0;
      for (int i = 0; i < 60 && acc_n < 2; i++) begin
         ready_seen = in_ready;
         @(posedge clk);
         cyc++;
         #1;
         if (out_valid && acc_n == 1) check("b2b_y", out_y, 16'h0006);
         if (ready_seen) begin
            acc_cyc[acc_n] = cyc;
            acc_n++;
         end
      end
      in_valid = 1'b0;
      check("b2b_count",    acc_n, 2);
      check("b2b_interval", acc_cyc[1] - acc_cyc[0], 11);
      repeat (12) tick();
      out_ready = 1'b0;
      check("b2b_drained", in_ready, 1);

      // Reset during RUN step 4 drops the op without a result.
      in_a = 16'h4000; in_b = 8'hFF; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      repeat (4) tick();
      check("mid_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_in_ready", in_ready, 1);
      check("mid_busy_off", busy,     0);
      check("mid_mult_rst", mult_rst, 1);
      ov_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) ov_cnt++;
      end
      check("mid_no_valid", ov_cnt, 0);
      run_op(16'h0100, 8'h02, 1'b0, y, lat, low_cnt, stable);
      check("post_rst_y", y, 16'h0002);
      pop();

      // Random ops with scrambled inputs during LOAD/RUN.
      rand_bad = 0; rand_lat_bad = 0; rand_unstable = 0;
      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom_range(0, 16'h7FFF));
         rb = BW'($urandom);
         run_op(ra, rb, 1'b1, y, lat, low_cnt, stable);
         if (y !== 16'((32'(ra) * 32'(rb)) >> BW)) rand_bad++;
         if (lat != 9) rand_lat_bad++;
         if (!stable) rand_unstable++;
         pop();
      end
      check("rand_results",  rand_bad,      0);
      check("rand_latency",  rand_lat_bad,  0);
      check("rand_operands", rand_unstable, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_mult16_seq.md
Name: shift_mult16_seq

Overview:
Posedge-clocked sequencer that drives the serial shift-add multiplier. The multiplier updates on negedge and does one step per clock. The block accepts an operand pair over a valid/ready handshake, holds the operands stable, and issues the multiplier's clear/load pulse. It counts exactly B_WIDTH multiplier steps, captures the 16-bit result and returns it over a second valid/ready handshake. It sits directly upstream of the multiplier and between it and the host/register interface.

Parameters:
B_WIDTH, 8, width of operand b; number of multiply steps; must match the multiplier's B_WIDTH; legal range 1..16
CNT_W, $clog2(B_WIDTH+1), step counter width (derived localparam, not overridable)

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
in_a  in  16  multiplicand
in_b  in  B_WIDTH  multiplier operand
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_y  out  16  result
busy  out  1  high in LOAD or RUN
mult_rst  out  1  to multiplier: clear accumulator, load b
mult_a  out  16  to multiplier: a operand
mult_b  out  B_WIDTH  to multiplier: b operand
mult_y  in  16  from multiplier: accumulator value

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, counter=0, operand regs=0, result reg=0.
  - Resulting outputs: in_ready=1, out_valid=0, out_y=0, busy=0, mult_rst=1, mult_a=0, mult_b=0.
  - Reset mid-operation (LOAD/RUN/DONE) aborts immediately. A pending result is discarded and no out_valid is issued.
- States: IDLE, LOAD, RUN, DONE. Outputs are decoded from registered state only; no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1, mult_rst=1.
  - When in_valid=1, capture in_a/in_b into operand regs and go to LOAD.
- LOAD (exactly 1 cycle):
  - mult_rst=1, so the negedge in this cycle clears the accumulator and latches mult_b.
  - Counter loads B_WIDTH. Next state is RUN.
- RUN (exactly B_WIDTH cycles):
  - mult_rst=0; one multiplier step per negedge.
  - Counter decrements each posedge.
  - On the posedge where counter==1, capture mult_y into the result reg and go to DONE.
- DONE:
  - out_valid=1, out_y=result reg, mult_rst=1.
  - When out_ready=1, go to IDLE.
  - out_y and out_valid hold stable while out_ready=0.
- mult_a/mult_b always drive the operand regs. These regs change only in IDLE on acceptance, so they are stable throughout LOAD and RUN.
- in_ready=1 only in IDLE. in_valid is ignored in LOAD/RUN/DONE; no queuing.
- Latency: acceptance posedge to first out_valid posedge = B_WIDTH+1 cycles. Minimum issue interval = B_WIDTH+3 cycles with out_ready held high.
- Arithmetic: out_y = floor(in_a*in_b / 2^B_WIDTH), valid for in_a < 2^15. For in_a >= 2^15 the result is the multiplier's 16-bit truncated value, passed through unmodified; the block does no saturation.
- Boundary cases:
  - in_b=0 gives out_y=0 after full latency; there is no early exit.
  - in_valid and out_ready changing in the same cycle as a state transition are honoured only in the state where they are sampled.
  - X on in_a/in_b while in_valid=0 must not propagate.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3)
  - the default B_WIDTH constant, shared with the multiplier instance
- No sub-module: FSM, counter and registers fit one module.
- The multiplier is instantiated by the parent, not inside this block.

Test Plan:
- Reset: hold rst 2 cycles -> in_ready=1, out_valid=0, mult_rst=1, out_y=0.
- Basic multiply (B_WIDTH=8): a=0x1000, b=0x80 -> out_valid asserted 9 cycles after accept; out_y=0x0800; mult_rst low for exactly 8 cycles.
- Max no-overflow operands: a=0x7FFF, b=0xFF -> out_y=0x7F7F; then a=0x1234, b=0x00 -> out_y=0x0000 after the same latency.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_y stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle; back-to-back issue interval = 11 cycles.
- Reset mid-RUN: assert rst at RUN step 4 -> IDLE next cycle, no out_valid; new op a=0x0100, b=0x02 -> out_y=0x0002.
- Operand stability: change in_a/in_b every cycle during LOAD/RUN -> mult_a/mult_b unchanged; scoreboard matches floor(a*b/256) over 200 random ops with a < 0x8000.
